// File: rtl/sound_sequencer.sv
// Game-event melody sequencer: arbitrates four event requests by fixed priority
// and steps a melody ROM in timed notes to drive the buzzer note/enable inputs.
module sound_sequencer #(
  parameter int TICK_CLKS = 250000,
  parameter int GAP_TICKS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       mute,
  output logic [3:0] note,
  output logic       enable,
  output logic       busy,
  output logic [1:0] cur_id
);

  localparam int             TW        = (TICK_CLKS > 1) ? $clog2(TICK_CLKS) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_CLKS - 1);
  localparam logic [5:0]     GAP_LAST  = 6'(GAP_TICKS - 1);
  localparam bit             HAS_GAP   = (GAP_TICKS > 0);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    PLAY,
    GAP
  } state_t;

  state_t        state_q, state_d;
  logic [1:0]    load_id_q, load_id_d;
  logic [1:0]    cur_id_q, cur_id_d;
  logic [2:0]    step_q, step_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [5:0]    dur_cnt_q, dur_cnt_d;
  logic [3:0]    pending_q, pending_d;

  logic [3:0] cur_note;
  logic [5:0] cur_dur;
  logic [5:0] next_dur;
  logic [1:0] req_hi;
  logic [1:0] active_id;
  logic       preempt;
  logic       tick_wrap;
  logic       play_expire;
  logic       gap_expire;
  logic       melody_end;
  logic       step_end;

  // ROM: {note, dur} per step; a zero duration terminates the melody.
  function automatic logic [3:0] rom_note(input logic [1:0] id, input logic [2:0] step);
    logic [3:0] n;
    n = 4'd0;
    case ({id, step})
      5'b00_000: n = 4'd8;
      5'b00_001: n = 4'd1;
      5'b01_000: n = 4'd10;
      5'b01_001: n = 4'd0;
      5'b01_010: n = 4'd10;
      5'b10_000: n = 4'd8;
      5'b10_001: n = 4'd9;
      5'b10_010: n = 4'd10;
      5'b11_000: n = 4'd1;
      5'b11_001: n = 4'd3;
      5'b11_010: n = 4'd5;
      5'b11_011: n = 4'd7;
      default:   n = 4'd0;
    endcase
    return n;
  endfunction

  function automatic logic [5:0] rom_dur(input logic [1:0] id, input logic [2:0] step);
    logic [5:0] d;
    d = 6'd0;
    case ({id, step})
      5'b00_000: d = 6'd4;
      5'b00_001: d = 6'd4;
      5'b01_000: d = 6'd10;
      5'b01_001: d = 6'd2;
      5'b01_010: d = 6'd10;
      5'b10_000: d = 6'd8;
      5'b10_001: d = 6'd8;
      5'b10_010: d = 6'd24;
      5'b11_000: d = 6'd8;
      5'b11_001: d = 6'd8;
      5'b11_010: d = 6'd8;
      5'b11_011: d = 6'd24;
      default:   d = 6'd0;
    endcase
    return d;
  endfunction

  function automatic logic [1:0] highest(input logic [3:0] v);
    logic [1:0] h;
    h = 2'd0;
    if (v[3])      h = 2'd3;
    else if (v[2]) h = 2'd2;
    else if (v[1]) h = 2'd1;
    return h;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      load_id_q <= 2'd0;
      cur_id_q  <= 2'd0;
      step_q    <= 3'd0;
      tick_q    <= '0;
      dur_cnt_q <= 6'd0;
      pending_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      load_id_q <= load_id_d;
      cur_id_q  <= cur_id_d;
      step_q    <= step_d;
      tick_q    <= tick_d;
      dur_cnt_q <= dur_cnt_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    load_id_d = load_id_q;
    cur_id_d  = cur_id_q;
    step_d    = step_q;
    tick_d    = tick_q;
    dur_cnt_d = dur_cnt_q;
    pending_d = pending_q;

    cur_note    = rom_note(cur_id_q, step_q);
    cur_dur     = rom_dur(cur_id_q, step_q);
    next_dur    = rom_dur(cur_id_q, step_q + 3'd1);
    req_hi      = highest(req);
    // During LOAD the melody being loaded is the one a new request competes with.
    active_id   = (state_q == LOAD) ? load_id_q : cur_id_q;
    preempt     = (state_q != IDLE) && (req != 4'd0) && (req_hi >= active_id);
    tick_wrap   = (tick_q == TICK_LAST);
    play_expire = tick_wrap && (dur_cnt_q == cur_dur - 6'd1);
    gap_expire  = tick_wrap && (dur_cnt_q == GAP_LAST);
    melody_end  = (step_q == 3'd7) || (next_dur == 6'd0);
    step_end    = ((state_q == PLAY) && play_expire && !HAS_GAP) ||
                  ((state_q == GAP) && gap_expire);

    if ((state_q == PLAY) || (state_q == GAP)) begin
      if (tick_wrap) begin
        tick_d    = '0;
        dur_cnt_d = dur_cnt_q + 6'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    if (state_q == IDLE) begin
      if ((pending_q | req) != 4'd0) begin
        state_d   = LOAD;
        load_id_d = highest(pending_q | req);
        pending_d = (pending_q | req) & ~(4'b0001 << highest(pending_q | req));
      end
    end else if (preempt) begin
      state_d   = LOAD;
      load_id_d = req_hi;
      pending_d = (pending_q | req) & ~(4'b0001 << req_hi);
    end else begin
      pending_d = pending_q | req;
      case (state_q)
        LOAD: begin
          cur_id_d  = load_id_q;
          step_d    = 3'd0;
          tick_d    = '0;
          dur_cnt_d = 6'd0;
          state_d   = PLAY;
        end
        PLAY: begin
          if (play_expire && HAS_GAP) begin
            tick_d    = '0;
            dur_cnt_d = 6'd0;
            state_d   = GAP;
          end
        end
        default: ;
      endcase

      // Leaving a step: continue the melody, hand over to the best pending one, or go idle.
      if (step_end) begin
        tick_d    = '0;
        dur_cnt_d = 6'd0;
        if (!melody_end) begin
          step_d  = step_q + 3'd1;
          state_d = PLAY;
        end else if (pending_d != 4'd0) begin
          load_id_d = highest(pending_d);
          pending_d = pending_d & ~(4'b0001 << highest(pending_d));
          state_d   = LOAD;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  assign note   = (state_q == PLAY) ? cur_note : 4'd0;
  assign enable = (state_q == PLAY) && (cur_note != 4'd0) && !mute;
  assign busy   = (state_q != IDLE);
  assign cur_id = cur_id_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Self-checking bench for sound_sequencer: directed event scenarios plus random
// request traffic, compared cycle by cycle against a per-cycle timeline model.
module tb_sound_sequencer;

   localparam int TICK = 4;
   localparam int GAPT = 1;

   logic       clk;
   logic       rst;
   logic [3:0] req;
   logic       mute;
   logic [3:0] note;
   logic       enable;
   logic       busy;
   logic [1:0] curId;

   int checkCount;
   int failCount;

   // Reference model: a melody is expanded into one note value per clock cycle
   int         romNote [4][8];
   int         romDur  [4][8];
   int         timeline[$];
   int         mdlMode;
   int         mdlLoadId;
   int         mdlCurId;
   logic [3:0] mdlPend;

   sound_sequencer #(
      .TICK_CLKS(TICK),
      .GAP_TICKS(GAPT)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .req   (req),
      .mute  (mute),
      .note  (note),
      .enable(enable),
      .busy  (busy),
      .cur_id(curId)
   );

   // Free-running 10 ns clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
      end
   endtask

   function automatic int hiIdx(input logic [3:0] v);
      int h;
      h = 0;
      for (int i = 0; i < 4; i++) if (v[i]) h = i;
      return h;
   endfunction

   function automatic void fillRom();
      for (int m = 0; m < 4; m++)
         for (int s = 0; s < 8; s++) begin
            romNote[m][s] = 0;
            romDur[m][s]  = 0;
         end
      romNote[0][0] = 8;  romDur[0][0] = 4;
      romNote[0][1] = 1;  romDur[0][1] = 4;
      romNote[1][0] = 10; romDur[1][0] = 10;
      romNote[1][1] = 0;  romDur[1][1] = 2;
      romNote[1][2] = 10; romDur[1][2] = 10;
      romNote[2][0] = 8;  romDur[2][0] = 8;
      romNote[2][1] = 9;  romDur[2][1] = 8;
      romNote[2][2] = 10; romDur[2][2] = 24;
      romNote[3][0] = 1;  romDur[3][0] = 8;
      romNote[3][1] = 3;  romDur[3][1] = 8;
      romNote[3][2] = 5;  romDur[3][2] = 8;
      romNote[3][3] = 7;  romDur[3][3] = 24;
   endfunction

   function automatic void buildTimeline(input int id);
      timeline.delete();
      for (int s = 0; s < 8; s++) begin
         if (romDur[id][s] == 0) break;
         for (int k = 0; k < romDur[id][s] * TICK; k++) timeline.push_back(romNote[id][s]);
         for (int k = 0; k < GAPT * TICK; k++) timeline.push_back(0);
      end
   endfunction

   function automatic void modelReset();
      mdlMode   = 0;
      mdlLoadId = 0;
      mdlCurId  = 0;
      mdlPend   = 4'd0;
      timeline.delete();
   endfunction

   function automatic void startLoad(input int id, input logic [3:0] cand);
      mdlMode   = 1;
      mdlLoadId = id;
      mdlPend   = cand & ~(4'b0001 << id);
   endfunction

   // Model update for one rising edge with request vector r
   function automatic void modelEdge(input logic [3:0] r);
      int active;
      if (mdlMode == 0) begin
         if ((mdlPend | r) != 4'd0) startLoad(hiIdx(mdlPend | r), mdlPend | r);
      end else begin
         active = (mdlMode == 1) ? mdlLoadId : mdlCurId;
         if (r != 4'd0 && hiIdx(r) >= active) begin
            startLoad(hiIdx(r), mdlPend | r);
         end else begin
            mdlPend = mdlPend | r;
            if (mdlMode == 1) begin
               mdlCurId = mdlLoadId;
               buildTimeline(mdlCurId);
               mdlMode = 2;
            end else begin
               void'(timeline.pop_front());
               if (timeline.size() == 0) begin
                  if (mdlPend != 4'd0) startLoad(hiIdx(mdlPend), mdlPend);
                  else mdlMode = 0;
               end
            end
         end
      end
   endfunction

   // Drive one cycle of inputs, advance the model on the edge, compare just after it
   task automatic applyStimulus(input logic [3:0] reqV, input logic muteV, input logic rstV);
      int expNote;
      @(negedge clk);
      req  = reqV;
      mute = muteV;
      rst  = rstV;
      @(posedge clk);
      if (rstV) modelReset();
      else modelEdge(reqV);
      #1;
      expNote = (mdlMode == 2) ? timeline[0] : 0;
      checkOutput("note", 32'(note), 32'(expNote));
      checkOutput("enable", 32'(enable), 32'((expNote != 0) && !muteV));
      checkOutput("busy", 32'(busy), 32'(mdlMode != 0));
      checkOutput("cur_id", 32'(curId), 32'(mdlCurId));
   endtask

   // Main sequence: directed scenarios followed by random traffic
   initial begin
      int obs;
      logic [3:0] rReq;
      logic rMute;
      checkCount = 0;
      failCount  = 0;
      fillRom();
      modelReset();
      req  = 4'd0;
      mute = 1'b0;
      rst  = 1'b1;

      // Reset and quiet idle
      for (int c = 0; c < 3; c++) applyStimulus(4'd0, 1'b0, 1'b1);
      checkOutput("t1_rst_note", 32'(note), 32'd0);
      checkOutput("t1_rst_busy", 32'(busy), 32'd0);
      checkOutput("t1_rst_cur_id", 32'(curId), 32'd0);
      for (int c = 0; c < 10; c++) applyStimulus(4'd0, 1'b0, 1'b0);
      checkOutput("t1_idle_busy", 32'(busy), 32'd0);

      // Drop melody timing
      for (int c = 0; c < 46; c++) begin
         applyStimulus((c == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
         obs = c + 1;
         if (obs == 1)  checkOutput("t2_load_busy", 32'(busy), 32'd1);
         if (obs == 1)  checkOutput("t2_load_note", 32'(note), 32'd0);
         if (obs == 2)  checkOutput("t2_first_note", 32'(note), 32'd8);
         if (obs == 17) checkOutput("t2_first_en", 32'(enable), 32'd1);
         if (obs == 18) checkOutput("t2_gap_note", 32'(note), 32'd0);
         if (obs == 22) checkOutput("t2_second_note", 32'(note), 32'd1);
         if (obs == 41) checkOutput("t2_last_busy", 32'(busy), 32'd1);
         if (obs == 42) checkOutput("t2_done_busy", 32'(busy), 32'd0);
      end

      // Win preempts drop
      for (int c = 0; c < 230; c++) begin
         applyStimulus((c == 0) ? 4'b0001 : (c == 10) ? 4'b1000 : 4'b0000, 1'b0, 1'b0);
         obs = c + 1;
         if (obs == 11)  checkOutput("t3_load_note", 32'(note), 32'd0);
         if (obs == 12)  checkOutput("t3_win_note", 32'(note), 32'd1);
         if (obs == 12)  checkOutput("t3_win_id", 32'(curId), 32'd3);
         if (obs == 220) checkOutput("t3_no_resume", 32'(busy), 32'd0);
      end

      // Invalid requested during win waits for it
      for (int c = 0; c < 320; c++) begin
         applyStimulus((c == 0) ? 4'b1000 : (c == 50) ? 4'b0010 : 4'b0000, 1'b0, 1'b0);
         obs = c + 1;
         if (obs == 51)  checkOutput("t4_win_kept", 32'(note), 32'd3);
         if (obs == 210) checkOutput("t4_load_busy", 32'(busy), 32'd1);
         if (obs == 211) checkOutput("t4_inval_note", 32'(note), 32'd10);
         if (obs == 211) checkOutput("t4_inval_id", 32'(curId), 32'd1);
         if (obs == 311) checkOutput("t4_done", 32'(busy), 32'd0);
      end

      // Muted drop melody
      for (int c = 0; c < 46; c++) begin
         applyStimulus((c == 0) ? 4'b0001 : 4'b0000, 1'b1, 1'b0);
         obs = c + 1;
         checkOutput("t5_muted_en", 32'(enable), 32'd0);
         if (obs == 2)  checkOutput("t5_note", 32'(note), 32'd8);
         if (obs == 42) checkOutput("t5_done", 32'(busy), 32'd0);
      end

      // Asynchronous reset mid-melody with a request in flight
      for (int c = 0; c < 20; c++) applyStimulus((c == 0) ? 4'b0001 : 4'b0000, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      req = 4'b0100;
      #1;
      checkOutput("t6_async_note", 32'(note), 32'd0);
      checkOutput("t6_async_en", 32'(enable), 32'd0);
      checkOutput("t6_async_busy", 32'(busy), 32'd0);
      checkOutput("t6_async_id", 32'(curId), 32'd0);
      modelReset();
      applyStimulus(4'b0100, 1'b0, 1'b1);
      for (int c = 0; c < 60; c++) applyStimulus(4'd0, 1'b0, 1'b0);
      checkOutput("t6_stays_idle", 32'(busy), 32'd0);

      // Random request traffic with occasional mute and reset
      rMute = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         rReq = ($urandom_range(0, 99) < 4) ? 4'($urandom_range(1, 15)) : 4'd0;
         if ($urandom_range(0, 99) < 2) rMute = ~rMute;
         applyStimulus(rReq, rMute, ($urandom_range(0, 999) < 2) ? 1'b1 : 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
      $finish;
   end

endmodule
